// File: rtl/dmac_ch_priority_arbiter_pkg.sv
// Shared types, reset constants and helpers for the DMA channel arbiter.
// The default channel count lives here so the interface and top agree on it.
package dmac_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_CH    = 8;
    localparam int DEF_PRI_WIDTH = 3;

    localparam arb_state_e ARB_IDLE_RST = IDLE;
    // The round-robin pointer starts on the last channel so channel 0 wins the first tie.
    localparam int LAST_CH_RST = DEF_NUM_CH - 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmac_ch_priority_arbiter_if.sv
// Request/grant bundle between the channel register bank, the arbiter and the AHB master engine.
// The master side drives requests and completion; the slave side is the arbiter itself.
interface dmac_arb_if
    import dmac_arb_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int PRI_WIDTH    = DEF_PRI_WIDTH,
    parameter int CH_IDX_WIDTH = clog2(NUM_CH)
);

    logic [NUM_CH-1:0]           ch_req;
    logic [NUM_CH*PRI_WIDTH-1:0] ch_pri;
    logic                        arb_en;
    logic                        grant_done;
    logic                        grant_vld;
    logic [CH_IDX_WIDTH-1:0]     grant_ch;
    logic [PRI_WIDTH-1:0]        grant_pri;
    logic [NUM_CH-1:0]           grant_onehot;

    modport master (
        output ch_req,
        output ch_pri,
        output arb_en,
        output grant_done,
        input  grant_vld,
        input  grant_ch,
        input  grant_pri,
        input  grant_onehot
    );

    modport slave (
        input  ch_req,
        input  ch_pri,
        input  arb_en,
        input  grant_done,
        output grant_vld,
        output grant_ch,
        output grant_pri,
        output grant_onehot
    );

endinterface

// File: rtl/dmac_ch_priority_arbiter_maxsel.sv
// Combinational masked max-priority search with a rotating tie-break.
// Among eligible channels at the highest priority, the first found scanning up from start_i wins.
module dmac_arb_maxsel
    import dmac_arb_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int PRI_WIDTH    = DEF_PRI_WIDTH,
    parameter int CH_IDX_WIDTH = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]           elig_i,
    input  logic [NUM_CH*PRI_WIDTH-1:0] pri_i,
    input  logic [CH_IDX_WIDTH-1:0]     start_i,
    output logic                        any_o,
    output logic [CH_IDX_WIDTH-1:0]     win_idx_o,
    output logic [PRI_WIDTH-1:0]        win_pri_o
);

    logic [PRI_WIDTH-1:0] max_pri;
    logic                 found;
    int                   idx;

    always_comb begin
        max_pri   = '0;
        found     = 1'b0;
        idx       = 0;
        win_idx_o = '0;
        any_o     = |elig_i;

        for (int i = 0; i < NUM_CH; i++) begin
            if (elig_i[i] && (pri_i[i*PRI_WIDTH +: PRI_WIDTH] > max_pri)) begin
                max_pri = pri_i[i*PRI_WIDTH +: PRI_WIDTH];
            end
        end

        // Rotated scan so equal-priority channels take turns behind the pointer.
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(start_i) + k) % NUM_CH;
            if (!found && elig_i[idx] && (pri_i[idx*PRI_WIDTH +: PRI_WIDTH] == max_pri)) begin
                found     = 1'b1;
                win_idx_o = CH_IDX_WIDTH'(idx);
            end
        end

        win_pri_o = max_pri;
    end

endmodule

// File: rtl/dmac_ch_priority_arbiter.sv
// DMA channel arbiter: IDLE/ARB/GRANT FSM holding a registered grant until the engine reports done.
// Requests are re-sampled in ARB; the grant is frozen for its whole lifetime.
module dmac_ch_priority_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int PRI_WIDTH    = DEF_PRI_WIDTH,
    parameter int CH_IDX_WIDTH = clog2(NUM_CH)
) (
    input  logic       hclk,
    input  logic       hresetn,
    dmac_arb_if.slave  bus
);

    localparam logic [CH_IDX_WIDTH-1:0] LastChInit = CH_IDX_WIDTH'(NUM_CH - 1);

    arb_state_e              state_q;
    logic [CH_IDX_WIDTH-1:0] last_ch_q;
    logic                    grant_vld_q;
    logic [CH_IDX_WIDTH-1:0] grant_ch_q;
    logic [PRI_WIDTH-1:0]    grant_pri_q;
    logic [NUM_CH-1:0]       grant_onehot_q;

    logic [NUM_CH-1:0]       elig_d;
    logic [CH_IDX_WIDTH-1:0] start_d;
    logic                    any_d;
    logic [CH_IDX_WIDTH-1:0] win_idx_d;
    logic [PRI_WIDTH-1:0]    win_pri_d;

    always_comb begin
        elig_d = bus.ch_req & {NUM_CH{bus.arb_en}};
        if (last_ch_q == LastChInit) begin
            start_d = '0;
        end else begin
            start_d = last_ch_q + 1'b1;
        end
    end

    dmac_arb_maxsel #(
        .NUM_CH       (NUM_CH),
        .PRI_WIDTH    (PRI_WIDTH),
        .CH_IDX_WIDTH (CH_IDX_WIDTH)
    ) u_maxsel (
        .elig_i    (elig_d),
        .pri_i     (bus.ch_pri),
        .start_i   (start_d),
        .any_o     (any_d),
        .win_idx_o (win_idx_d),
        .win_pri_o (win_pri_d)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q        <= ARB_IDLE_RST;
            last_ch_q      <= LastChInit;
            grant_vld_q    <= 1'b0;
            grant_ch_q     <= '0;
            grant_pri_q    <= '0;
            grant_onehot_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arb_en && (|bus.ch_req)) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (any_d) begin
                        grant_vld_q    <= 1'b1;
                        grant_ch_q     <= win_idx_d;
                        grant_pri_q    <= win_pri_d;
                        grant_onehot_q <= NUM_CH'(1) << win_idx_d;
                        last_ch_q      <= win_idx_d;
                        state_q        <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    // grant_ch/grant_pri deliberately keep the finished grant's values.
                    if (bus.grant_done) begin
                        grant_vld_q    <= 1'b0;
                        grant_onehot_q <= '0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_vld    = grant_vld_q;
    assign bus.grant_ch     = grant_ch_q;
    assign bus.grant_pri    = grant_pri_q;
    assign bus.grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_dmac_ch_priority_arbiter.sv
// Scoreboard bench for the DMA channel arbiter: expected grants are queued as stimulus is
// driven and compared when grant_vld rises; latency, hold and reset behaviour are checked inline.
module tb_dmac_ch_priority_arbiter;

    typedef struct {
        int ch;
        int pri;
        int onehot;
    } grantExp_t;

    logic hclk;
    logic hresetn;

    dmac_arb_if bus ();

    dmac_ch_priority_arbiter dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    grantExp_t expQ[$];
    int testsRun   = 0;
    int failCount  = 0;
    int grantCount = 0;
    logic prevVld  = 1'b0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic [23:0] pri, input logic en);
        bus.ch_req = req;
        bus.ch_pri = pri;
        bus.arb_en = en;
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic pulseDone();
        bus.grant_done = 1'b1;
        tick();
        bus.grant_done = 1'b0;
    endtask

    task automatic pushExp(input int ch, input int pri);
        grantExp_t e;
        e.ch     = ch;
        e.pri    = pri;
        e.onehot = 1 << ch;
        expQ.push_back(e);
    endtask

    task automatic waitGrants(input int target);
        for (int i = 0; i < 20; i++) begin
            if (grantCount >= target) break;
            tick();
        end
        checkOutput("grant_wait", 32'(grantCount >= target), 32'd1);
    endtask

    task automatic doReset();
        hresetn = 1'b0;
        tick();
        tick();
        hresetn = 1'b1;
    endtask

    function automatic logic [23:0] uniformPri(input logic [2:0] p);
        logic [23:0] v;
        for (int i = 0; i < 8; i++) v[i*3 +: 3] = p;
        return v;
    endfunction

    // Pop the oldest expectation on each new grant.
    always @(negedge hclk) begin
        grantExp_t e;
        if (bus.grant_vld && !prevVld) begin
            grantCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_grant", 32'(bus.grant_ch), 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("grant_ch", 32'(bus.grant_ch), 32'(e.ch));
                checkOutput("grant_pri", 32'(bus.grant_pri), 32'(e.pri));
                checkOutput("grant_onehot", 32'(bus.grant_onehot), 32'(e.onehot));
            end
        end
        prevVld = bus.grant_vld;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got stuck, expected finish");
        $fatal(1, "[TB] bench timed out");
    end

    initial begin
        logic [23:0] pri;
        int base;

        hresetn = 1'b0;
        bus.grant_done = 1'b0;
        applyStimulus(8'h00, 24'h0, 1'b1);
        tick();
        tick();
        checkOutput("rst_vld", 32'(bus.grant_vld), 32'd0);
        checkOutput("rst_ch", 32'(bus.grant_ch), 32'd0);
        checkOutput("rst_pri", 32'(bus.grant_pri), 32'd0);
        checkOutput("rst_onehot", 32'(bus.grant_onehot), 32'd0);
        hresetn = 1'b1;
        tick();

        $display("[TB] single request");
        pushExp(2, 0);
        applyStimulus(8'h04, 24'h0, 1'b1);
        tick();
        checkOutput("lat_e0", 32'(bus.grant_vld), 32'd0);
        tick();
        checkOutput("lat_e1", 32'(bus.grant_vld), 32'd1);
        tick();
        applyStimulus(8'h00, 24'h0, 1'b1);
        pulseDone();
        checkOutput("done_vld", 32'(bus.grant_vld), 32'd0);
        checkOutput("done_onehot", 32'(bus.grant_onehot), 32'd0);
        checkOutput("done_ch_keep", 32'(bus.grant_ch), 32'd2);
        pulseDone();
        tick();
        checkOutput("idle_done_ignored", 32'(bus.grant_vld), 32'd0);

        $display("[TB] priority win");
        pri = uniformPri(3'd3);
        pri[1*3 +: 3] = 3'd5;
        pri[6*3 +: 3] = 3'd7;
        pushExp(6, 7);
        applyStimulus(8'hFF, pri, 1'b1);
        waitGrants(2);
        applyStimulus(8'h00, pri, 1'b1);
        pulseDone();
        tick();

        $display("[TB] round-robin tie");
        doReset();
        base = grantCount;
        pushExp(0, 4);
        pushExp(3, 4);
        pushExp(7, 4);
        pushExp(0, 4);
        applyStimulus(8'b1000_1001, uniformPri(3'd4), 1'b1);
        for (int g = 0; g < 4; g++) begin
            waitGrants(base + g + 1);
            if (g == 3) applyStimulus(8'h00, uniformPri(3'd4), 1'b1);
            pulseDone();
        end
        tick();
        tick();

        $display("[TB] hold and ignore");
        base = grantCount;
        pri = '0;
        pri[2*3 +: 3] = 3'd1;
        pri[5*3 +: 3] = 3'd7;
        pushExp(2, 1);
        applyStimulus(8'h04, pri, 1'b1);
        waitGrants(base + 1);
        applyStimulus(8'h20, pri, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("hold_vld", 32'(bus.grant_vld), 32'd1);
        checkOutput("hold_ch", 32'(bus.grant_ch), 32'd2);
        checkOutput("hold_pri", 32'(bus.grant_pri), 32'd1);
        checkOutput("hold_onehot", 32'(bus.grant_onehot), 32'h04);
        pushExp(5, 7);
        pulseDone();
        waitGrants(base + 2);
        applyStimulus(8'h00, pri, 1'b1);
        pulseDone();
        tick();

        $display("[TB] vanishing request and disable");
        applyStimulus(8'h01, 24'h0, 1'b1);
        tick();
        applyStimulus(8'h00, 24'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("vanish_vld", 32'(bus.grant_vld), 32'd0);
        applyStimulus(8'hFF, 24'h0, 1'b1);
        tick();
        applyStimulus(8'hFF, 24'h0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("en_drop_vld", 32'(bus.grant_vld), 32'd0);
        checkOutput("disabled_onehot", 32'(bus.grant_onehot), 32'd0);
        applyStimulus(8'h00, 24'h0, 1'b1);
        tick();

        $display("[TB] async reset mid-grant");
        base = grantCount;
        pushExp(6, 2);
        applyStimulus(8'hFF, uniformPri(3'd2), 1'b1);
        waitGrants(base + 1);
        #2;
        hresetn = 1'b0;
        #1;
        checkOutput("arst_vld", 32'(bus.grant_vld), 32'd0);
        checkOutput("arst_ch", 32'(bus.grant_ch), 32'd0);
        checkOutput("arst_onehot", 32'(bus.grant_onehot), 32'd0);
        checkOutput("arst_pri", 32'(bus.grant_pri), 32'd0);
        tick();
        hresetn = 1'b1;
        pushExp(0, 2);
        waitGrants(base + 2);
        applyStimulus(8'h00, 24'h0, 1'b1);
        pulseDone();
        tick();
        tick();

        checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/dmac_ch_priority_arbiter.md
# dmac_ch_priority_arbiter

Sequential channel arbiter for the AHB DMA controller. It samples per-channel transfer requests and their programmable priorities, and selects the highest-priority requesting channel using a max-search over the priority vector. Ties are broken round-robin. It holds a registered grant until the granted channel's engine signals completion. It sits between the channel register bank and the shared AHB master engine.

## Interface
- NUM_CH, 8, number of DMA channels (2..16)
- PRI_WIDTH, 3, priority field width per channel; unsigned; larger value = higher priority
- CH_IDX_WIDTH, 3, channel index width = ceil(log2(NUM_CH))

- hclk  in  1  AHB clock; all state changes on rising edge
- hresetn  in  1  reset, asynchronous, active-low
- ch_req  in  NUM_CH  per-channel request level; bit i = channel i
- ch_pri  in  NUM_CH*PRI_WIDTH  concatenated priorities; channel i at [i*PRI_WIDTH +: PRI_WIDTH]
- arb_en  in  1  global enable; 0 blocks new grants
- grant_done  in  1  single-cycle pulse from the master engine: the current grant is finished
- grant_vld  out  1  a grant is active
- grant_ch  out  CH_IDX_WIDTH  index of the granted channel
- grant_pri  out  PRI_WIDTH  priority captured at grant
- grant_onehot  out  NUM_CH  one-hot form of grant_ch; all zero when grant_vld = 0

## Operation
- States: IDLE, ARB, GRANT.
- IDLE:
  - If arb_en = 1 and |ch_req = 1, go to ARB.
  - Otherwise stay in IDLE.
- ARB, one cycle; ch_req and ch_pri are re-sampled in this cycle:
  - Eligible set = ch_req & {NUM_CH{arb_en}}.
  - If the eligible set is empty, return to IDLE with no grant.
  - Otherwise find the maximum priority among eligible channels.
  - Among the channels at that priority, pick the first one found scanning upward from (last_ch+1) mod NUM_CH.
  - Register grant_ch, grant_pri and grant_onehot, set grant_vld, update last_ch to the chosen channel, and go to GRANT.
- GRANT:
  - Outputs are frozen.
  - Changes to ch_req, ch_pri or arb_en have no effect. A granted channel that drops its request keeps the grant.
  - On grant_done = 1, clear grant_vld and grant_onehot and go to IDLE. grant_ch and grant_pri keep their last values.
- grant_done in IDLE or ARB is ignored.
- Priority compare is unsigned, full PRI_WIDTH. Channels with equal priority are never starved: round-robin among them is fair.
- last_ch reset value = NUM_CH-1, so channel 0 wins the first tie.
- Reset values: grant_vld = 0, grant_ch = 0, grant_pri = 0, grant_onehot = 0, state = IDLE, last_ch = NUM_CH-1.
- Reset mid-GRANT clears everything asynchronously. No completion is implied to the engine.

## Timing
- Request to grant:
  - ch_req is sampled high at edge E0, and state becomes ARB.
  - grant_vld = 1 after edge E1.
  - Latency is 2 cycles.
- Done to next grant:
  - grant_done is sampled at edge D0, and grant_vld falls after D0.
  - IDLE samples at D1 and ARB registers at D2.
  - There are at least 2 dead cycles between back-to-back grants.
- All outputs are registered. There is no combinational path from inputs to outputs.
- If grant_done and a new request arrive in the same cycle, done completes first. The new request is arbitrated via IDLE→ARB.
- If arb_en drops in ARB, the arbiter returns to IDLE with no grant.

## Structure
- Shared package dmac_arb_pkg holds:
  - the state enum (IDLE, ARB, GRANT);
  - the ARB_IDLE_RST / LAST_CH_RST constants;
  - helper function clog2.
- Sub-module dmac_arb_maxsel (combinational):
  - inputs: eligible mask, ch_pri, start pointer;
  - outputs: winning index and priority;
  - implements a masked unsigned max-search with rotated tie-break.
- The top level contains the FSM, last_ch register and output registers only.

## Test plan
- Single request: ch_req = 8'b0000_0100, all priorities 0 → grant_vld rises 2 cycles later with grant_ch = 2 and grant_onehot = 8'h04. Pulse grant_done → grant_vld = 0 on the next edge.
- Priority win: ch_req = 8'hFF with ch1 pri 5, ch6 pri 7, others pri 3 → grant_ch = 6 and grant_pri = 7.
- Round-robin tie:
  - ch_req = 8'b1000_1001, all pri 4, held high, done pulsed after each grant.
  - Required grant sequence is 0, 3, 7, 0.
- Hold and ignore:
  - After granting ch2, drop ch_req[2] and raise ch5 with pri 7.
  - grant stays on ch2 until grant_done, then the next grant is ch5.
- Vanishing request / disable:
  - ch_req pulses for 1 cycle only (IDLE sample), low in ARB → no grant, back to IDLE.
  - arb_en = 0 with ch_req = 8'hFF → grant_vld stays 0.
- Async reset:
  - Assert hresetn = 0 mid-GRANT → grant_vld, grant_ch and grant_onehot go to 0 immediately.
  - After release, a tie with all channels requesting grants ch0 first.
